// File: rtl/fpmul_round_pack.sv
// Rounding/packing stage behind the FP multiplier: applies the RISC-V rounding mode,
// packs an IEEE-754 single plus fflags, and hands it on through a 2-entry skid buffer.
module fpmul_round_pack #(
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  sign_i,
    input  logic [7:0]            exp_i,
    input  logic [46:0]           mant_i,
    input  logic                  is_nan_i,
    input  logic                  nv_i,
    input  logic                  is_inf_i,
    input  logic                  is_zero_i,
    input  logic [2:0]            rm_i,
    input  logic [ADDR_WIDTH-1:0] rd_i,
    input  logic                  fp_reg_write_i,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           result_o,
    output logic [4:0]            fflags_o,
    output logic [ADDR_WIDTH-1:0] rd_o,
    output logic                  fp_reg_write_o
);

    typedef enum logic [1:0] {EMPTY, HOLD, FULL} state_t;

    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;

    state_t state, state_next;

    logic                  lsb, guard, sticky, inc, inexact, ovf, unf;
    logic [30:0]           sum;
    logic [31:0]           rnd_result;
    logic [4:0]            rnd_flags;

    logic [31:0]           skid_result;
    logic [4:0]            skid_flags;
    logic [ADDR_WIDTH-1:0] skid_rd;
    logic                  skid_fp_reg_write;

    logic accept, load_out, load_skid, skid_to_out;

    // Rounding and packing, purely combinational on the incoming beat.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        inc        = 1'b0;
        rnd_result = 32'h0;
        rnd_flags  = 5'b0;

        lsb     = mant_i[24];
        guard   = mant_i[23];
        sticky  = |mant_i[22:0];
        inexact = guard | sticky;

        case (rm_i)
            RM_RTZ:  inc = 1'b0;
            RM_RDN:  inc = inexact & sign_i;
            RM_RUP:  inc = inexact & ~sign_i;
            RM_RMM:  inc = guard;
            default: inc = guard & (sticky | lsb);
        endcase

        // A fraction carry ripples into the exponent, so subnormals can become min normal.
        sum = {exp_i, mant_i[46:24]} + 31'(inc);
        ovf = (exp_i == 8'hFF) || (sum[30:23] == 8'hFF);
        unf = inexact && (exp_i == 8'h00) && (sum[30:23] == 8'h00);

        if (is_nan_i) begin
            rnd_result = 32'h7FC0_0000;
            rnd_flags  = {nv_i, 4'b0};
        end else if (is_inf_i) begin
            rnd_result = {sign_i, 8'hFF, 23'h0};
            rnd_flags  = {nv_i, 4'b0};
        end else if (is_zero_i) begin
            rnd_result = {sign_i, 31'h0};
        end else if (ovf) begin
            rnd_flags = 5'b00101;
            case (rm_i)
                RM_RTZ:  rnd_result = {sign_i, 31'h7F7F_FFFF};
                RM_RDN:  rnd_result = sign_i ? 32'hFF80_0000 : 32'h7F7F_FFFF;
                RM_RUP:  rnd_result = sign_i ? 32'hFF7F_FFFF : 32'h7F80_0000;
                default: rnd_result = {sign_i, 8'hFF, 23'h0};
            endcase
        end else begin
            rnd_result = {sign_i, sum};
            rnd_flags  = {3'b0, unf, inexact};
        end
    end

    assign accept    = in_valid & in_ready;
    assign out_valid = (state != EMPTY);

    always_comb begin
        state_next  = state;
        load_out    = 1'b0;
        load_skid   = 1'b0;
        skid_to_out = 1'b0;
        case (state)
            EMPTY: if (accept) begin
                state_next = HOLD;
                load_out   = 1'b1;
            end
            HOLD: begin
                if (accept && out_ready) begin
                    load_out = 1'b1;
                end else if (accept) begin
                    state_next = FULL;
                    load_skid  = 1'b1;
                end else if (out_ready) begin
                    state_next = EMPTY;
                end
            end
            FULL: if (out_ready) begin
                state_next  = HOLD;
                skid_to_out = 1'b1;
            end
            default: state_next = EMPTY;
        endcase
        if (clear) begin
            state_next  = EMPTY;
            load_out    = 1'b0;
            load_skid   = 1'b0;
            skid_to_out = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= EMPTY;
            in_ready          <= 1'b1;
            result_o          <= 32'h0;
            fflags_o          <= 5'b0;
            rd_o              <= '0;
            fp_reg_write_o    <= 1'b0;
            skid_result       <= 32'h0;
            skid_flags        <= 5'b0;
            skid_rd           <= '0;
            skid_fp_reg_write <= 1'b0;
        end else begin
            state    <= state_next;
            in_ready <= (state_next != FULL);
            if (load_out) begin
                result_o       <= rnd_result;
                fflags_o       <= rnd_flags;
                rd_o           <= rd_i;
                fp_reg_write_o <= fp_reg_write_i;
            end else if (skid_to_out) begin
                result_o       <= skid_result;
                fflags_o       <= skid_flags;
                rd_o           <= skid_rd;
                fp_reg_write_o <= skid_fp_reg_write;
            end
            if (load_skid) begin
                skid_result       <= rnd_result;
                skid_flags        <= rnd_flags;
                skid_rd           <= rd_i;
                skid_fp_reg_write <= fp_reg_write_i;
            end
        end
    end

endmodule

// File: tb/tb_fpmul_round_pack.sv
// Directed bench for fpmul_round_pack: rounding modes, special cases, overflow,
// skid-buffer ordering, clear and asynchronous reset.
`timescale 1ns/1ps
module tb_fpmul_round_pack;

    logic        clk = 1'b0;
    logic        rst, clear, in_valid, in_ready;
    logic        sign_i, is_nan_i, nv_i, is_inf_i, is_zero_i, fp_reg_write_i;
    logic [7:0]  exp_i;
    logic [46:0] mant_i;
    logic [2:0]  rm_i;
    logic [4:0]  rd_i, rd_o;
    logic        out_valid, out_ready, fp_reg_write_o;
    logic [31:0] result_o;
    logic [4:0]  fflags_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fpmul_round_pack #(.ADDR_WIDTH(5)) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready),
        .sign_i(sign_i), .exp_i(exp_i), .mant_i(mant_i),
        .is_nan_i(is_nan_i), .nv_i(nv_i), .is_inf_i(is_inf_i), .is_zero_i(is_zero_i),
        .rm_i(rm_i), .rd_i(rd_i), .fp_reg_write_i(fp_reg_write_i),
        .out_valid(out_valid), .out_ready(out_ready),
        .result_o(result_o), .fflags_o(fflags_o),
        .rd_o(rd_o), .fp_reg_write_o(fp_reg_write_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic sgn, input logic [7:0] e, input logic [22:0] frac,
                         input logic g, input logic [22:0] st, input logic [2:0] rm,
                         input logic [4:0] rd);
        sign_i         = sgn;
        exp_i          = e;
        mant_i         = {frac, g, st};
        rm_i           = rm;
        rd_i           = rd;
        fp_reg_write_i = rd[0];
        is_nan_i       = 1'b0;
        nv_i           = 1'b0;
        is_inf_i       = 1'b0;
        is_zero_i      = 1'b0;
    endtask

    // Sends the currently driven beat with out_ready=1, checks it, then lets it drain.
    task automatic send_check(input string tag, input logic [31:0] exp_res,
                              input logic [4:0] exp_flags);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
        chk({tag, "_result"}, result_o, exp_res);
        chk({tag, "_flags"}, {27'b0, fflags_o}, {27'b0, exp_flags});
        chk({tag, "_rd"}, {27'b0, rd_o}, {27'b0, rd_i});
        chk({tag, "_fpw"}, {31'b0, fp_reg_write_o}, {31'b0, rd_i[0]});
        step();
        chk({tag, "_drain"}, {31'b0, out_valid}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        drive(1'b0, 8'h00, 23'h0, 1'b0, 23'h0, 3'b000, 5'd0);
        #12;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_result", result_o, 32'h0);
        chk("rst_flags", {27'b0, fflags_o}, 32'd0);
        chk("rst_rd", {27'b0, rd_o}, 32'd0);
        chk("rst_fpw", {31'b0, fp_reg_write_o}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step();

        // Plain normal values and the four rounding directions.
        drive(1'b0, 8'h7F, 23'h400000, 1'b0, 23'h0, 3'b000, 5'd1);
        send_check("exact_1p5", 32'h3FC0_0000, 5'b00000);
        drive(1'b0, 8'h7F, 23'h7FFFFF, 1'b1, 23'h0, 3'b000, 5'd2);
        send_check("rne_carry", 32'h4000_0000, 5'b00001);
        drive(1'b0, 8'h7F, 23'h7FFFFF, 1'b1, 23'h0, 3'b001, 5'd3);
        send_check("rtz_trunc", 32'h3FFF_FFFF, 5'b00001);
        drive(1'b0, 8'h00, 23'h7FFFFF, 1'b1, 23'h0, 3'b000, 5'd4);
        send_check("sub_to_norm", 32'h0080_0000, 5'b00001);
        drive(1'b0, 8'h7F, 23'h000000, 1'b1, 23'h0, 3'b000, 5'd5);
        send_check("rne_tie_even", 32'h3F80_0000, 5'b00001);
        drive(1'b0, 8'h7F, 23'h000000, 1'b1, 23'h0, 3'b100, 5'd6);
        send_check("rmm_tie", 32'h3F80_0001, 5'b00001);
        drive(1'b0, 8'h7F, 23'h000000, 1'b1, 23'h0, 3'b101, 5'd7);
        send_check("rm101_as_rne", 32'h3F80_0000, 5'b00001);
        drive(1'b0, 8'h7F, 23'h000000, 1'b0, 23'h000400, 3'b011, 5'd8);
        send_check("rup_sticky", 32'h3F80_0001, 5'b00001);
        drive(1'b1, 8'h7F, 23'h000000, 1'b0, 23'h000400, 3'b011, 5'd9);
        send_check("rup_neg_trunc", 32'hBF80_0000, 5'b00001);
        drive(1'b0, 8'h00, 23'h000001, 1'b1, 23'h0, 3'b000, 5'd10);
        send_check("underflow", 32'h0000_0002, 5'b00011);
        drive(1'b1, 8'h00, 23'h000005, 1'b0, 23'h000001, 3'b010, 5'd11);
        send_check("uf_rdn_neg", 32'h8000_0006, 5'b00011);

        // Overflow boundary.
        drive(1'b0, 8'hFE, 23'h7FFFFF, 1'b1, 23'h0, 3'b000, 5'd12);
        send_check("ovf_rne", 32'h7F80_0000, 5'b00101);
        drive(1'b0, 8'hFE, 23'h7FFFFF, 1'b1, 23'h0, 3'b001, 5'd13);
        send_check("max_rtz", 32'h7F7F_FFFF, 5'b00001);
        drive(1'b1, 8'hFE, 23'h7FFFFF, 1'b1, 23'h0, 3'b011, 5'd14);
        send_check("max_rup_neg", 32'hFF7F_FFFF, 5'b00001);
        drive(1'b0, 8'hFF, 23'h000000, 1'b0, 23'h0, 3'b001, 5'd15);
        send_check("ovf_rtz", 32'h7F7F_FFFF, 5'b00101);
        drive(1'b1, 8'hFF, 23'h000000, 1'b0, 23'h0, 3'b010, 5'd16);
        send_check("ovf_rdn_neg", 32'hFF80_0000, 5'b00101);
        drive(1'b1, 8'hFF, 23'h000000, 1'b0, 23'h0, 3'b011, 5'd17);
        send_check("ovf_rup_neg", 32'hFF7F_FFFF, 5'b00101);

        // Special-case priority.
        drive(1'b1, 8'hFF, 23'h123456, 1'b1, 23'h1, 3'b000, 5'd18);
        is_nan_i = 1'b1; nv_i = 1'b1; is_inf_i = 1'b1;
        send_check("nan", 32'h7FC0_0000, 5'b10000);
        drive(1'b1, 8'h7F, 23'h000001, 1'b1, 23'h1, 3'b000, 5'd19);
        is_inf_i = 1'b1; is_zero_i = 1'b1;
        send_check("inf_neg", 32'hFF80_0000, 5'b00000);
        drive(1'b1, 8'hFF, 23'h000001, 1'b1, 23'h1, 3'b000, 5'd20);
        is_zero_i = 1'b1;
        send_check("zero_neg", 32'h8000_0000, 5'b00000);

        // Back-pressure: three beats offered, two fit, third waits.
        out_ready = 1'b0;
        drive(1'b0, 8'h7F, 23'h000001, 1'b0, 23'h0, 3'b000, 5'd3);
        in_valid = 1'b1;
        step();
        chk("bp_in_ready_1", {31'b0, in_ready}, 32'd1);
        drive(1'b0, 8'h7F, 23'h000002, 1'b0, 23'h0, 3'b000, 5'd4);
        step();
        chk("bp_in_ready_2", {31'b0, in_ready}, 32'd0);
        drive(1'b0, 8'h7F, 23'h000003, 1'b0, 23'h0, 3'b000, 5'd5);
        step();
        chk("bp_stall_ready", {31'b0, in_ready}, 32'd0);
        chk("bp_stall_rd", {27'b0, rd_o}, 32'd3);
        chk("bp_stall_res", result_o, 32'h3F80_0001);
        out_ready = 1'b1;
        step();
        chk("bp_2nd_rd", {27'b0, rd_o}, 32'd4);
        chk("bp_2nd_res", result_o, 32'h3F80_0002);
        chk("bp_2nd_ready", {31'b0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        chk("bp_3rd_rd", {27'b0, rd_o}, 32'd5);
        chk("bp_3rd_res", result_o, 32'h3F80_0003);
        chk("bp_3rd_valid", {31'b0, out_valid}, 32'd1);
        step();
        chk("bp_empty", {31'b0, out_valid}, 32'd0);

        // Clear while FULL with a beat on offer.
        out_ready = 1'b0;
        drive(1'b0, 8'h80, 23'h0, 1'b0, 23'h0, 3'b000, 5'd6);
        in_valid = 1'b1;
        step();
        drive(1'b0, 8'h81, 23'h0, 1'b0, 23'h0, 3'b000, 5'd7);
        step();
        chk("clr_full", {31'b0, in_ready}, 32'd0);
        drive(1'b0, 8'h82, 23'h0, 1'b0, 23'h0, 3'b000, 5'd9);
        clear = 1'b1;
        out_ready = 1'b1;
        step();
        clear = 1'b0;
        in_valid = 1'b0;
        chk("clr_valid", {31'b0, out_valid}, 32'd0);
        chk("clr_ready", {31'b0, in_ready}, 32'd1);
        step();
        chk("clr_dropped", {31'b0, out_valid}, 32'd0);

        // Asynchronous reset while holding a result.
        out_ready = 1'b0;
        drive(1'b1, 8'h90, 23'h55, 1'b0, 23'h0, 3'b000, 5'd21);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("hold_valid", {31'b0, out_valid}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", {31'b0, out_valid}, 32'd0);
        chk("arst_result", result_o, 32'h0);
        chk("arst_rd", {27'b0, rd_o}, 32'd0);
        chk("arst_fpw", {31'b0, fp_reg_write_o}, 32'd0);
        chk("arst_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
